alu_result_buf: RTL and testbench

- Small FIFO between the ALU functional unit's combinational outputs and the CDB arbiter.
- Captures completed ALU results (dest tag, 64-bit result, branch mask).
- Presents the oldest live entry as a CDB request and holds it until granted.
- Applies branch-resolution updates to every buffered entry: clears the resolved mask bit, and kills entries dependent on a mispredicted branch.

---
 rtl/sys_defs.sv | 26 ++
 rtl/bmask_update.sv | 17 +
 rtl/alu_result_buf.sv | 96 +++++++++
 tb/tb_alu_result_buf.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared processor types for functional-unit result buffering.
// Also provides the branch-mask bit clear used when a branch resolves.
package sys_defs;

  typedef logic [63:0] DATA;
  typedef logic [5:0]  PHYS_REG;
  typedef logic [3:0]  B_MASK;
  typedef logic [1:0]  BS_PTR;

  localparam int ALU_BUF_DEPTH = 4;

  typedef struct packed {
    logic    live;
    PHYS_REG tag;
    DATA     result;
    B_MASK   bmask;
  } FU_BUF_ENTRY;

  function automatic B_MASK clear_bmask_bit(input B_MASK m, input logic resolved, input BS_PTR ptr);
    B_MASK r;
    r = m;
    if (resolved) r[ptr] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bmask_update.sv
// Applies one branch resolution to a single buffered entry's mask.
// Combinational, zero latency; no flow control.
module bmask_update
  import sys_defs::*;
(
  input  B_MASK bmask,
  input  logic  resolved,
  input  logic  wrong,
  input  BS_PTR bs_ptr,
  output B_MASK bmask_next,
  output logic  kill
);

  assign bmask_next = clear_bmask_bit(bmask, resolved, bs_ptr);
  assign kill       = resolved & wrong & bmask[bs_ptr];

endmodule

// File: rtl/alu_result_buf.sv
// Result FIFO between the ALU and the CDB arbiter, with branch-kill support.
// Latency 1 cycle (no bypass); head held until granted, buf_stall at DEPTH-1.
module alu_result_buf
  import sys_defs::*;
#(
  parameter int DEPTH = ALU_BUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           alu_done,
  input  PHYS_REG        alu_tagDest,
  input  DATA            alu_result,
  input  B_MASK          alu_bmask,
  input  logic           br_branch_resolved,
  input  logic           br_pred_wrong,
  input  BS_PTR          br_bs_ptr,
  input  logic           cdb_grant,
  output logic           cdb_req,
  output PHYS_REG        cdb_tag,
  output DATA            cdb_result,
  output B_MASK          cdb_bmask,
  output logic           buf_stall,
  output logic [PTR_W:0] buf_count
);

  localparam logic [PTR_W:0] STALL_AT = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] FULL_AT  = (PTR_W+1)'(DEPTH);

  FU_BUF_ENTRY      slots [DEPTH];
  B_MASK            upd_bmask [DEPTH];
  logic [DEPTH-1:0] upd_kill;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  B_MASK            in_bmask;
  logic             not_empty;
  logic             head_live;
  logic             full;
  logic             deq;
  logic             enq;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    bmask_update u_upd (
      .bmask      (slots[i].bmask),
      .resolved   (br_branch_resolved),
      .wrong      (br_pred_wrong),
      .bs_ptr     (br_bs_ptr),
      .bmask_next (upd_bmask[i]),
      .kill       (upd_kill[i])
    );
  end

  assign in_bmask  = clear_bmask_bit(alu_bmask, br_branch_resolved, br_bs_ptr);
  assign not_empty = (count != '0);
  assign head_live = slots[head].live;
  assign full      = (count == FULL_AT);

  assign cdb_req    = not_empty & head_live & ~upd_kill[head];
  assign cdb_tag    = slots[head].tag;
  assign cdb_result = slots[head].result;
  assign cdb_bmask  = upd_bmask[head];
  assign buf_stall  = (count >= STALL_AT);
  assign buf_count  = count;

  // Dead slots at the head retire on their own, one per cycle.
  assign deq = (cdb_req & cdb_grant) | (not_empty & ~head_live);
  assign enq = alu_done & (~full | deq);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].bmask <= upd_bmask[i];
        if (upd_kill[i]) slots[i].live <= 1'b0;
      end
      if (enq) begin
        slots[tail] <= '{live: 1'b1, tag: alu_tagDest, result: alu_result, bmask: in_bmask};
        tail        <= tail + PTR_W'(1);
      end
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(alu_done && full && !deq));

endmodule

// File: tb/tb_alu_result_buf.sv
// Randomized and directed bench for alu_result_buf against a queue-based reference model.
module tb_alu_result_buf;
  import sys_defs::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       alu_done = 1'b0;
  PHYS_REG    alu_tagDest = '0;
  DATA        alu_result = '0;
  B_MASK      alu_bmask = '0;
  logic       br_branch_resolved = 1'b0;
  logic       br_pred_wrong = 1'b0;
  BS_PTR      br_bs_ptr = '0;
  logic       cdb_grant = 1'b0;
  logic       cdb_req;
  PHYS_REG    cdb_tag;
  DATA        cdb_result;
  B_MASK      cdb_bmask;
  logic       buf_stall;
  logic [2:0] buf_count;

  alu_result_buf dut (
    .clock(clock), .reset(reset), .alu_done(alu_done), .alu_tagDest(alu_tagDest),
    .alu_result(alu_result), .alu_bmask(alu_bmask), .br_branch_resolved(br_branch_resolved),
    .br_pred_wrong(br_pred_wrong), .br_bs_ptr(br_bs_ptr), .cdb_grant(cdb_grant),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_result(cdb_result), .cdb_bmask(cdb_bmask),
    .buf_stall(buf_stall), .buf_count(buf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       live;
    bit [5:0] tag;
    bit [63:0] res;
    bit [3:0] bm;
  } ent_t;

  ent_t     q[$];
  bit [5:0] seen_tag[$];
  bit [3:0] seen_bm[$];
  int       total = 0;
  int       bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model at the edge.
  task automatic step(input bit d, input bit [5:0] t, input bit [63:0] r, input bit [3:0] bm,
                      input bit rv, input bit wr, input bit [1:0] bp, input bit g);
    bit   exp_req, deq;
    bit [3:0] hb;
    ent_t e;
    @(negedge clock);
    alu_done = d; alu_tagDest = t; alu_result = r; alu_bmask = bm;
    br_branch_resolved = rv; br_pred_wrong = wr; br_bs_ptr = bp; cdb_grant = g;
    #1;
    exp_req = 0;
    if (q.size() > 0) exp_req = q[0].live && !(rv && wr && q[0].bm[bp]);
    chk("req", {63'd0, cdb_req}, {63'd0, exp_req});
    chk("count", {61'd0, buf_count}, 64'(q.size()));
    chk("stall", {63'd0, buf_stall}, {63'd0, q.size() >= 3});
    if (exp_req && cdb_req) begin
      hb = q[0].bm;
      if (rv) hb[bp] = 1'b0;
      chk("tag", {58'd0, cdb_tag}, {58'd0, q[0].tag});
      chk("result", cdb_result, q[0].res);
      chk("bmask", {60'd0, cdb_bmask}, {60'd0, hb});
      if (g) begin
        seen_tag.push_back(cdb_tag);
        seen_bm.push_back(cdb_bmask);
      end
    end
    @(posedge clock);
    deq = (exp_req && g) || (q.size() > 0 && !q[0].live);
    foreach (q[i]) begin
      e = q[i];
      if (rv) begin
        if (wr && e.bm[bp]) e.live = 0;
        e.bm[bp] = 1'b0;
      end
      q[i] = e;
    end
    if (deq) void'(q.pop_front());
    if (d) begin
      e.live = 1; e.tag = t; e.res = r; e.bm = bm;
      if (rv) e.bm[bp] = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit g);
    step(0, 0, 0, 0, 0, 0, 0, g);
  endtask

  task automatic enq(input bit [5:0] t, input bit [3:0] bm);
    step(1, t, 64'h100 + 64'(t), bm, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) idle(1);
  endtask

  initial begin
    bit [3:0] rbm;
    bit [1:0] rbp;
    bit rv;
    #12;
    chk("rst_req", {63'd0, cdb_req}, 64'd0);
    chk("rst_count", {61'd0, buf_count}, 64'd0);
    chk("rst_stall", {63'd0, buf_stall}, 64'd0);
    chk("rst_tag", {58'd0, cdb_tag}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single result, grant held: broadcast one cycle after enqueue.
    step(1, 5, 64'h10, 4'b0000, 0, 0, 0, 1);
    idle(1);
    idle(1);
    chk("single_n", 64'(seen_tag.size()), 64'd1);
    if (seen_tag.size() > 0) chk("single_tag", {58'd0, seen_tag[0]}, 64'd5);

    // Fill to four, then drain in order.
    seen_tag.delete(); seen_bm.delete();
    enq(1, 0); enq(2, 0); enq(3, 0); enq(4, 0);
    idle(0);
    drain();
    chk("order_n", 64'(seen_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen_tag.size(); i++) chk("order_tag", {58'd0, seen_tag[i]}, 64'(i + 1));

    // Mispredict kills the head even though it is granted.
    seen_tag.delete(); seen_bm.delete();
    enq(7, 4'b0010); enq(8, 4'b0001);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    idle(1); idle(1); idle(1);
    chk("kill_n", 64'(seen_tag.size()), 64'd1);
    if (seen_tag.size() > 0) chk("kill_survivor", {58'd0, seen_tag[0]}, 64'd8);

    // Correct prediction clears the bit on the same-cycle broadcast.
    seen_tag.delete(); seen_bm.delete();
    enq(7, 4'b0010); enq(8, 4'b0001);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    drain();
    chk("clr_n", 64'(seen_tag.size()), 64'd2);
    if (seen_tag.size() > 0) chk("clr_bmask", {60'd0, seen_bm[0]}, 64'd0);

    // Enqueue while the head is granted: count holds, order preserved across wrap.
    seen_tag.delete(); seen_bm.delete();
    enq(3, 0); enq(6, 0);
    step(1, 9, 64'h99, 0, 0, 0, 0, 1);
    drain();
    chk("wrap_n", 64'(seen_tag.size()), 64'd3);
    if (seen_tag.size() == 3) chk("wrap_last", {58'd0, seen_tag[2]}, 64'd9);

    // Asynchronous reset mid-cycle.
    enq(11, 0); enq(12, 0); enq(13, 0);
    @(negedge clock);
    alu_done = 0; br_branch_resolved = 0; cdb_grant = 1;
    #2 reset = 1'b1;
    #1;
    chk("arst_req", {63'd0, cdb_req}, 64'd0);
    chk("arst_count", {61'd0, buf_count}, 64'd0);
    chk("arst_stall", {63'd0, buf_stall}, 64'd0);
    q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(1); idle(1); idle(1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rv  = ($urandom_range(3) == 0);
      rbp = 2'($urandom_range(3));
      rbm = 4'($urandom_range(15));
      if (rv) rbm[rbp] = 1'b0;
      step((q.size() < 4) && ($urandom_range(1) == 1), 6'($urandom_range(63)),
           {$urandom, $urandom}, rbm, rv, $urandom_range(1) == 1, rbp, $urandom_range(3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
